branch_resolve_queue: RTL and testbench
=======================================

Name: branch_resolve_queue

Overview:
- Carries each fetch-stage prediction (PC, predicted direction, predicted target) to the execute stage and compares it with the actual outcome.
- Drives the update ports of the branch predictor and branch target buffer.
- Generates the fetch redirect on a misprediction.
- Sits between the fetch-side predictor read port and the EX-stage branch resolution logic; it is the producer end of the predictor/BTB update interface.

Parameters:
- DEPTH, 4, queue entries; power of two, at least 2.
- PC_W, 32, PC/target width.

Ports:
- clk  input  1  clock
- rst  input  1  reset; one clock; reset is asynchronous and active-low
- i_push  input  1  fetch hands an instruction to decode; record its prediction
- i_push_pc  input  PC_W  PC of that instruction
- i_push_pred_taken  input  1  predictor output (BTB valid AND predict-taken)
- i_push_pred_target  input  PC_W  BTB target used by fetch
- o_full  output  1  queue holds DEPTH entries
- o_empty  output  1  queue holds 0 entries
- i_pop  input  1  head instruction resolves in EX this cycle
- i_ex_is_branch  input  1  head instruction is a conditional branch
- i_ex_taken  input  1  actual branch outcome
- i_ex_target  input  PC_W  computed branch target (PC+imm)
- i_flush  input  1  external flush (exception/trap); discard all entries
- o_head_pc  output  PC_W  PC of head entry; 0 when empty
- o_upd_valid  output  1  update strobe to predictor/BTB
- o_upd_pc  output  PC_W  PC being updated
- o_upd_is_branch  output  1  drives predictor/BTB is-branch input
- o_upd_taken  output  1  drives predictor/BTB taken input
- o_upd_target  output  PC_W  drives BTB target input
- o_redirect  output  1  one-cycle fetch redirect pulse
- o_redirect_pc  output  PC_W  correct next PC
- o_overflow  output  1  sticky: push attempted while full without pop
- o_branch_cnt  output  32  resolved branch count (optional feature)
- o_mispredict_cnt  output  32  mispredict count (optional feature)

Behaviour:
- Storage:
  - Circular buffer with read/write pointers of log2(DEPTH)+1 bits.
  - Full = same index, MSB differs. Empty = pointers equal.
  - Pointer wrap is natural modulo 2*DEPTH.
- Reset (rst low, asynchronous): pointers 0, o_empty=1, o_full=0, all o_upd_* 0, o_redirect 0, o_redirect_pc 0, o_overflow 0, counters 0. Entry contents are don't-care.
- Push:
  - Accepted when not full, or when full and a valid pop happens in the same cycle.
  - Push while full without pop: dropped, o_overflow set until reset.
- Pop:
  - Valid only when not empty. i_pop while empty is ignored and produces no update.
- Resolution, evaluated combinationally on the head entry when a pop is valid:
  - actual_next = (i_ex_is_branch & i_ex_taken) ? i_ex_target : head_pc+4
  - pred_next = head_pred_taken ? head_pred_target : head_pc+4
  - All additions are modulo 2^PC_W.
  - mispredict = (actual_next != pred_next).
- Update port, registered with 1-cycle latency after the pop edge:
  - o_upd_valid=1 for exactly one cycle.
  - o_upd_pc=head_pc, o_upd_is_branch=i_ex_is_branch, o_upd_taken=i_ex_taken, o_upd_target=i_ex_target.
  - A non-branch pop still pulses o_upd_valid, with o_upd_is_branch=0, so the downstream tables do not change.
  - o_upd_* data holds its last value while o_upd_valid=0.
- Redirect:
  - On a mispredicting pop, o_redirect=1 for one cycle in the next cycle, with o_redirect_pc=actual_next.
  - At that same edge the queue is flushed (pointers equal, o_empty=1). Any same-cycle push is discarded as wrong-path.
  - o_redirect_pc holds between pulses.
- i_flush: all entries discarded at the edge; same-cycle push and pop are ignored. No update and no redirect is produced.
- i_flush and a mispredicting pop in the same cycle: i_flush wins, giving no update and no redirect.
- Back-to-back pops: one update per cycle; the update stream is never stalled by this block.
- Reset asserted mid-operation: everything clears immediately. An in-progress update or redirect pulse is truncated.

Optional Feature:
- Macro BRQ_PERF_CNT_EN.
- Defined:
  - o_branch_cnt increments on each valid pop with i_ex_is_branch=1.
  - o_mispredict_cnt increments on each mispredicting valid pop.
  - Both counters saturate at 32'hFFFFFFFF.
  - Both are cleared by reset only, not by flush.
- Undefined: both ports are tied to 0, no counter flops are built, and the port list is unchanged.

Test Plan:
- Correct not-taken: push pc=0x100, pred_taken=0; pop with is_branch=1, taken=0 -> next cycle upd_valid=1, upd_pc=0x100, upd_taken=0; no redirect; o_empty=1.
- Taken mispredict: push 0x200 (pred 0) and 0x204; pop 0x200 with taken=1, target=0x80 -> redirect=1, redirect_pc=0x80 next cycle; queue empty (0x204 discarded); upd_taken=1, upd_target=0x80.
- Wrong target: push 0x300, pred_taken=1, pred_target=0x400; pop with taken=1, target=0x500 -> redirect_pc=0x500. Repeat with target=0x400 -> no redirect.
- Non-branch BTB alias: push 0x40, pred_taken=1, target=0x10; pop with is_branch=0 -> redirect_pc=0x44, upd_is_branch=0.
- Full/wrap (DEPTH=4):
  - 4 pushes -> o_full=1.
  - 5th push without pop -> dropped, o_overflow=1.
  - Simultaneous push and pop while full -> accepted.
  - Cycle 10 entries through the queue -> FIFO order preserved across pointer wrap.
- Flush priority and reset:
  - i_flush with a mispredicting pop -> no redirect, no update, queue empty.
  - Assert rst mid-stream -> all outputs 0 asynchronously.
  - With BRQ_PERF_CNT_EN: 3 branches, 1 mispredict -> counters 3 and 1.

Source files
------------

// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: carries fetch predictions to EX, resolves them, drives predictor/BTB updates and redirects.
// Optional perf counters are built only when BRQ_PERF_CNT_EN is defined.
module branch_resolve_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_push,
  input  logic [PC_W-1:0] i_push_pc,
  input  logic            i_push_pred_taken,
  input  logic [PC_W-1:0] i_push_pred_target,
  output logic            o_full,
  output logic            o_empty,
  input  logic            i_pop,
  input  logic            i_ex_is_branch,
  input  logic            i_ex_taken,
  input  logic [PC_W-1:0] i_ex_target,
  input  logic            i_flush,
  output logic [PC_W-1:0] o_head_pc,
  output logic            o_upd_valid,
  output logic [PC_W-1:0] o_upd_pc,
  output logic            o_upd_is_branch,
  output logic            o_upd_taken,
  output logic [PC_W-1:0] o_upd_target,
  output logic            o_redirect,
  output logic [PC_W-1:0] o_redirect_pc,
  output logic            o_overflow,
  output logic [31:0]     o_branch_cnt,
  output logic [31:0]     o_mispredict_cnt
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PC_W-1:0] pc_mem [DEPTH];
  logic [PC_W-1:0] tgt_mem [DEPTH];
  logic taken_mem [DEPTH];
  logic [PC_W-1:0] head_pc, head_tgt, actual_next, pred_next;
  logic head_taken, pop_ok, push_ok, mispredict;
  logic overflow_q, overflow_d;
  logic upd_valid_q, upd_valid_d, upd_is_branch_q, upd_is_branch_d, upd_taken_q, upd_taken_d;
  logic [PC_W-1:0] upd_pc_q, upd_pc_d, upd_target_q, upd_target_d;
  logic redirect_q, redirect_d;
  logic [PC_W-1:0] redirect_pc_q, redirect_pc_d;
  assign o_empty = wr_ptr_q == rd_ptr_q;
  assign o_full = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_pc = pc_mem[rd_ptr_q[AW-1:0]];
  assign head_tgt = tgt_mem[rd_ptr_q[AW-1:0]];
  assign head_taken = taken_mem[rd_ptr_q[AW-1:0]];
  assign o_head_pc = o_empty ? '0 : head_pc;
  always_comb begin
    pop_ok = i_pop & ~o_empty & ~i_flush;
    actual_next = (i_ex_is_branch & i_ex_taken) ? i_ex_target : head_pc + PC_W'(4);
    pred_next = head_taken ? head_tgt : head_pc + PC_W'(4);
    mispredict = pop_ok & (actual_next != pred_next);
    // a mispredict squashes the younger same-cycle push as wrong-path
    push_ok = i_push & ~i_flush & ~mispredict & (~o_full | pop_ok);
    wr_ptr_d = wr_ptr_q + (AW+1)'(push_ok);
    rd_ptr_d = (i_flush | mispredict) ? wr_ptr_q : rd_ptr_q + (AW+1)'(pop_ok);
    overflow_d = overflow_q | (i_push & ~i_flush & o_full & ~pop_ok);
    upd_valid_d = pop_ok;
    upd_pc_d = pop_ok ? head_pc : upd_pc_q;
    upd_is_branch_d = pop_ok ? i_ex_is_branch : upd_is_branch_q;
    upd_taken_d = pop_ok ? i_ex_taken : upd_taken_q;
    upd_target_d = pop_ok ? i_ex_target : upd_target_q;
    redirect_d = mispredict;
    redirect_pc_d = mispredict ? actual_next : redirect_pc_q;
  end
  always_ff @(posedge clk) begin
    if (push_ok) begin
      pc_mem[wr_ptr_q[AW-1:0]] <= i_push_pc;
      tgt_mem[wr_ptr_q[AW-1:0]] <= i_push_pred_target;
      taken_mem[wr_ptr_q[AW-1:0]] <= i_push_pred_taken;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      overflow_q <= 1'b0;
      upd_valid_q <= 1'b0;
      upd_pc_q <= '0;
      upd_is_branch_q <= 1'b0;
      upd_taken_q <= 1'b0;
      upd_target_q <= '0;
      redirect_q <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      overflow_q <= overflow_d;
      upd_valid_q <= upd_valid_d;
      upd_pc_q <= upd_pc_d;
      upd_is_branch_q <= upd_is_branch_d;
      upd_taken_q <= upd_taken_d;
      upd_target_q <= upd_target_d;
      redirect_q <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end
  assign o_overflow = overflow_q;
  assign o_upd_valid = upd_valid_q;
  assign o_upd_pc = upd_pc_q;
  assign o_upd_is_branch = upd_is_branch_q;
  assign o_upd_taken = upd_taken_q;
  assign o_upd_target = upd_target_q;
  assign o_redirect = redirect_q;
  assign o_redirect_pc = redirect_pc_q;
`ifdef BRQ_PERF_CNT_EN
  logic [31:0] branch_cnt_q, branch_cnt_d, mispredict_cnt_q, mispredict_cnt_d;
  always_comb begin
    branch_cnt_d = branch_cnt_q + 32'(pop_ok & i_ex_is_branch & ~&branch_cnt_q);
    mispredict_cnt_d = mispredict_cnt_q + 32'(mispredict & ~&mispredict_cnt_q);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      branch_cnt_q <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      branch_cnt_q <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end
  assign o_branch_cnt = branch_cnt_q;
  assign o_mispredict_cnt = mispredict_cnt_q;
`else
  assign o_branch_cnt = '0;
  assign o_mispredict_cnt = '0;
`endif
endmodule

// File: tb/tb_branch_resolve_queue.sv
// tb_branch_resolve_queue: scoreboard bench; a reference queue model predicts updates, redirects and flags.
module tb_branch_resolve_queue;
  localparam int DEPTH = 4;
`ifdef BRQ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  typedef struct {logic [31:0] pc; logic pt; logic [31:0] ptgt;} ent_t;
  typedef struct {logic [31:0] pc; logic isb; logic tk; logic [31:0] tgt; logic mis; logic [31:0] rpc;} upd_t;
  logic clk = 1'b0, rst = 1'b0;
  logic i_push = 0, i_push_pred_taken = 0, i_pop = 0, i_ex_is_branch = 0, i_ex_taken = 0, i_flush = 0;
  logic [31:0] i_push_pc = 0, i_push_pred_target = 0, i_ex_target = 0;
  logic o_full, o_empty, o_upd_valid, o_upd_is_branch, o_upd_taken, o_redirect, o_overflow;
  logic [31:0] o_head_pc, o_upd_pc, o_upd_target, o_redirect_pc, o_branch_cnt, o_mispredict_cnt;
  ent_t mq[$];
  upd_t exp_q[$];
  logic ovf = 0;
  int bcnt = 0, mcnt = 0, checks = 0, errors = 0;
  branch_resolve_queue #(.DEPTH(DEPTH), .PC_W(32)) dut (
    .clk(clk), .rst(rst), .i_push(i_push), .i_push_pc(i_push_pc),
    .i_push_pred_taken(i_push_pred_taken), .i_push_pred_target(i_push_pred_target),
    .o_full(o_full), .o_empty(o_empty), .i_pop(i_pop), .i_ex_is_branch(i_ex_is_branch),
    .i_ex_taken(i_ex_taken), .i_ex_target(i_ex_target), .i_flush(i_flush),
    .o_head_pc(o_head_pc), .o_upd_valid(o_upd_valid), .o_upd_pc(o_upd_pc),
    .o_upd_is_branch(o_upd_is_branch), .o_upd_taken(o_upd_taken), .o_upd_target(o_upd_target),
    .o_redirect(o_redirect), .o_redirect_pc(o_redirect_pc), .o_overflow(o_overflow),
    .o_branch_cnt(o_branch_cnt), .o_mispredict_cnt(o_mispredict_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(input logic push, input logic [31:0] pc, input logic pt, input logic [31:0] ptgt,
                      input logic pop, input logic isb, input logic tk, input logic [31:0] tgt, input logic flush);
    logic full_before, pop_v, mis;
    logic [31:0] act, pred;
    ent_t h;
    upd_t e;
    i_push = push; i_push_pc = pc; i_push_pred_taken = pt; i_push_pred_target = ptgt;
    i_pop = pop; i_ex_is_branch = isb; i_ex_taken = tk; i_ex_target = tgt; i_flush = flush;
    full_before = mq.size() == DEPTH;
    pop_v = pop && mq.size() > 0;
    mis = 1'b0;
    if (flush) mq.delete();
    else begin
      if (pop_v) begin
        h = mq.pop_front();
        act = (isb && tk) ? tgt : h.pc + 32'd4;
        pred = h.pt ? h.ptgt : h.pc + 32'd4;
        mis = act != pred;
        e = '{h.pc, isb, tk, tgt, mis, act};
        exp_q.push_back(e);
        if (isb) bcnt++;
        if (mis) begin mcnt++; mq.delete(); end
      end
      if (push && !mis) begin
        if (full_before && !pop_v) ovf = 1'b1;
        else mq.push_back('{pc, pt, ptgt});
      end
    end
    @(posedge clk);
    #1;
    i_push = 0; i_pop = 0; i_flush = 0;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("upd_valid", o_upd_valid, 1);
      chk("upd_pc", o_upd_pc, e.pc);
      chk("upd_is_branch", o_upd_is_branch, e.isb);
      chk("upd_taken", o_upd_taken, e.tk);
      chk("upd_target", o_upd_target, e.tgt);
      chk("redirect", o_redirect, e.mis);
      if (e.mis) chk("redirect_pc", o_redirect_pc, e.rpc);
    end else begin
      chk("upd_idle", o_upd_valid, 0);
      chk("redirect_idle", o_redirect, 0);
    end
    chk("empty", o_empty, mq.size() == 0);
    chk("full", o_full, mq.size() == DEPTH);
    chk("head_pc", o_head_pc, mq.size() > 0 ? mq[0].pc : 32'd0);
    chk("overflow", o_overflow, ovf);
    @(negedge clk);
  endtask
  task automatic push_only(input logic [31:0] pc, input logic pt, input logic [31:0] ptgt);
    step(1, pc, pt, ptgt, 0, 0, 0, 0, 0);
  endtask
  task automatic pop_only(input logic isb, input logic tk, input logic [31:0] tgt);
    step(0, 0, 0, 0, 1, isb, tk, tgt, 0);
  endtask
  task automatic check_reset(input string tag);
    chk({tag, "_empty"}, o_empty, 1);
    chk({tag, "_full"}, o_full, 0);
    chk({tag, "_upd_valid"}, o_upd_valid, 0);
    chk({tag, "_upd_pc"}, o_upd_pc, 0);
    chk({tag, "_redirect"}, o_redirect, 0);
    chk({tag, "_redirect_pc"}, o_redirect_pc, 0);
    chk({tag, "_overflow"}, o_overflow, 0);
    chk({tag, "_head_pc"}, o_head_pc, 0);
    chk({tag, "_branch_cnt"}, o_branch_cnt, 0);
    chk({tag, "_mis_cnt"}, o_mispredict_cnt, 0);
  endtask
  initial begin
    #1;
    check_reset("rst0");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    push_only(32'h100, 0, 0);
    pop_only(1, 0, 0);
    push_only(32'h200, 0, 0);
    push_only(32'h204, 0, 0);
    pop_only(1, 1, 32'h80);
    push_only(32'h300, 1, 32'h400);
    pop_only(1, 1, 32'h500);
    push_only(32'h300, 1, 32'h400);
    pop_only(1, 1, 32'h400);
    push_only(32'h40, 1, 32'h10);
    pop_only(0, 0, 0);
    for (int i = 0; i < 4; i++) push_only(32'h1000 + 32'(4 * i), 0, 0);
    push_only(32'h2000, 0, 0);
    step(1, 32'h1010, 0, 0, 1, 1, 0, 32'h9999, 0);
    for (int i = 0; i < 10; i++) step(1, 32'h3000 + 32'(4 * i), 0, 0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) pop_only(0, 0, 0);
    pop_only(1, 1, 32'h50);
    push_only(32'h500, 0, 0);
    step(1, 32'h504, 0, 0, 1, 1, 1, 32'h900, 1);
    for (int i = 0; i < 60; i++)
      step($urandom_range(0, 1), $urandom & 32'hFFFF_FFFC, $urandom_range(0, 1), $urandom & 32'hFFFF_FFFC,
           $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), $urandom & 32'hFFFF_FFFC,
           $urandom_range(0, 15) == 0);
    chk("branch_cnt", o_branch_cnt, PERF ? 32'(bcnt) : 32'd0);
    chk("mis_cnt", o_mispredict_cnt, PERF ? 32'(mcnt) : 32'd0);
    push_only(32'h700, 1, 32'h800);
    push_only(32'h704, 0, 0);
    pop_only(1, 0, 0);
    rst = 1'b0;
    #1;
    check_reset("rst_mid");
    mq.delete(); exp_q.delete(); ovf = 0; bcnt = 0; mcnt = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    push_only(32'h900, 0, 0);
    pop_only(1, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
